// File: rtl/alu_issue_ctrl.sv
// Execute-stage issue controller: decodes RV32 ALU instructions and buffers them
// in a main/skid register pair. Optional illegal-opcode flag: ALU_ISSUE_ILLEGAL_TRAP_EN.
module alu_issue_ctrl #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [DATA_W-1:0] in_pc,
    input  logic [DATA_W-1:0] in_rs1,
    input  logic [DATA_W-1:0] in_rs2,
    input  logic [DATA_W-1:0] in_imm,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [4:0]        out_alu_op,
    output logic [1:0]        out_mode_sel,
    output logic [DATA_W-1:0] out_pc,
    output logic [DATA_W-1:0] out_rs1,
    output logic [DATA_W-1:0] out_rs2,
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    output logic              out_illegal,
`endif
    output logic [DATA_W-1:0] out_imm
);

    typedef enum logic [4:0] {
        ALU_ADD  = 5'b00000,
        ALU_SUB  = 5'b00001,
        ALU_SLL  = 5'b00010,
        ALU_SLT  = 5'b00011,
        ALU_SLTU = 5'b00100,
        ALU_XOR  = 5'b00101,
        ALU_SRL  = 5'b00110,
        ALU_SRA  = 5'b00111,
        ALU_OR   = 5'b01000,
        ALU_AND  = 5'b01001
    } alu_op_t;

    typedef enum logic [1:0] {
        MODE_RR = 2'b00,
        MODE_RI = 2'b01,
        MODE_PI = 2'b10
    } mode_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b10
    } state_t;

    typedef struct packed {
        logic [4:0]        alu_op;
        logic [1:0]        mode_sel;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] rs1;
        logic [DATA_W-1:0] rs2;
        logic [DATA_W-1:0] imm;
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
        logic              illegal;
`endif
    } bundle_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    function automatic alu_op_t alu_from_funct3(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic       w_bit30;
    logic       w_unused;
    logic       w_accept;
    logic       w_consume;
    bundle_t    w_dec;

    state_t  r_state;
    logic    r_in_ready;
    logic    r_out_valid;
    bundle_t r_m;
    bundle_t r_s;

    assign w_opcode = in_instr[6:0];
    assign w_funct3 = in_instr[14:12];
    assign w_bit30  = in_instr[30];
    assign w_unused = ^{in_instr[31], in_instr[29:15], in_instr[11:7]};

    // NOTE: every field gets a default first so no path through the case leaves a latch.
    always_comb begin
        w_dec          = '0;
        w_dec.alu_op   = ALU_ADD;
        w_dec.mode_sel = MODE_RR;
        w_dec.pc       = in_pc;
        w_dec.rs1      = in_rs1;
        w_dec.rs2      = in_rs2;
        w_dec.imm      = in_imm;
        case (w_opcode)
            OPC_OP: begin
                w_dec.alu_op = alu_from_funct3(w_funct3, w_bit30);
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
                w_dec.illegal = (in_instr[31:25] != 7'b0000000) &&
                                (in_instr[31:25] != 7'b0100000);
`endif
            end
            OPC_OP_IMM: begin
                // Only the shift-right encoding uses bit30; addi ignores it.
                w_dec.alu_op   = alu_from_funct3(w_funct3, (w_funct3 == 3'b101) && w_bit30);
                w_dec.mode_sel = MODE_RI;
            end
            OPC_LUI: begin
                w_dec.mode_sel = MODE_RI;
                w_dec.rs1      = '0;
            end
            OPC_AUIPC, OPC_JAL: w_dec.mode_sel = MODE_PI;
            OPC_LOAD, OPC_STORE, OPC_JALR: w_dec.mode_sel = MODE_RI;
            OPC_BRANCH: begin
                case (w_funct3[2:1])
                    2'b00:   w_dec.alu_op = ALU_SUB;
                    2'b10:   w_dec.alu_op = ALU_SLT;
                    2'b11:   w_dec.alu_op = ALU_SLTU;
                    default: w_dec.alu_op = ALU_SUB;
                endcase
            end
            default: begin
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
                w_dec.illegal = 1'b1;
`endif
            end
        endcase
    end

    assign w_accept  = in_valid && r_in_ready;
    assign w_consume = r_out_valid && out_ready;

    // in_ready is computed from the next state only, so out_ready never reaches it combinationally.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_m         <= '0;
            // NOTE: the skid entry is never observed while invalid, so its contents need no reset.
        end else if (flush) begin
            r_state     <= ST_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        r_m         <= w_dec;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_consume) begin
                        r_m <= w_dec;
                    end else if (w_accept) begin
                        r_s        <= w_dec;
                        r_in_ready <= 1'b0;
                        r_state    <= ST_FULL;
                    end else if (w_consume) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_consume) begin
                        r_m        <= r_s;
                        r_in_ready <= 1'b1;
                        r_state    <= ST_ONE;
                    end
                end
                default: begin
                    r_state     <= ST_EMPTY;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready     = r_in_ready;
    assign out_valid    = r_out_valid;
    assign out_alu_op   = r_m.alu_op;
    assign out_mode_sel = r_m.mode_sel;
    assign out_pc       = r_m.pc;
    assign out_rs1      = r_m.rs1;
    assign out_rs2      = r_m.rs2;
    assign out_imm      = r_m.imm;
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    assign out_illegal  = r_m.illegal;
`endif

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Execute-stage issue controller for the RV32 ALU datapath. It accepts decoded instructions from the decode stage over a valid/ready handshake, derives the 5-bit ALU opcode and 2-bit operand-mux select, and buffers the result in a two-entry skid register. It then presents a registered, stall-tolerant operand bundle to the ALU operand mux and ALU. It decouples decode back-pressure from execute stalls and applies pipeline flushes.

## Interface
- `DATA_W`: default 32. Width of PC, register and immediate operands.
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: synchronous reset, active low.
- `in_valid`, input, 1: decode offers an instruction.
- `in_ready`, output, 1: controller can accept; registered.
- `in_instr`, input, 32: raw instruction; uses opcode[6:0], funct3[14:12], funct7 bit 30.
- `in_pc`, input, DATA_W: instruction PC.
- `in_rs1`, input, DATA_W: rs1 read data.
- `in_rs2`, input, DATA_W: rs2 read data.
- `in_imm`, input, DATA_W: sign-extended immediate from decode.
- `flush`, input, 1: discard all buffered and incoming instructions.
- `out_valid`, output, 1: issue bundle valid.
- `out_ready`, input, 1: execute consumes the bundle.
- `out_alu_op`, output, 5: ALU opcode.
- `out_mode_sel`, output, 2: operand-mux select.
- `out_pc`, output, DATA_W: issued PC.
- `out_rs1`, output, DATA_W: issued rs1 data.
- `out_rs2`, output, DATA_W: issued rs2 data.
- `out_imm`, output, DATA_W: issued immediate.
- `out_illegal`, output, 1: unsupported opcode flag. Present only with the macro in Configuration.

## Operation
- ALU op encoding:
  - ADD 00000, SUB 00001, SLL 00010, SLT 00011, SLTU 00100
  - XOR 00101, SRL 00110, SRA 00111, OR 01000, AND 01001
  - All other codes are reserved.
- Mode select encoding: 00 reg/reg, 01 reg/imm, 10 pc/imm. Code 11 is never emitted.
- OP (0110011):
  - Mode 00. Op is selected by funct3: 000 ADD, or SUB when bit30=1; 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 SRL, or SRA when bit30=1; 110 OR; 111 AND.
- OP-IMM (0010011):
  - Mode 01. Same funct3 map as OP.
  - Bit30 selects SRA only when funct3=101. For funct3=000, bit30 is ignored and the op is always ADD.
- LUI (0110111): mode 01, ADD. `out_rs1` is forced to 0.
- AUIPC (0010111) and JAL (1101111): mode 10, ADD.
- LOAD (0000011), STORE (0100011) and JALR (1100111): mode 01, ADD.
- BRANCH (1100011): mode 00. Op is SUB for funct3 000/001, SLT for 100/101, SLTU for 110/111.
- Any other opcode: ADD, mode 00. `out_illegal`=1 when the macro is compiled in.
- Storage: one main register M drives the outputs; one skid register S is used under back-pressure.
- States:
  - EMPTY (M invalid, S invalid)
  - ONE (M valid, S invalid)
  - FULL (M valid, S valid)
- Transitions:
  - Accept occurs when `in_valid & in_ready`. Consume occurs when `out_valid & out_ready`.
  - EMPTY + accept → ONE.
  - ONE + accept + consume → ONE; M is loaded with the new instruction.
  - ONE + accept, no consume → FULL; the new instruction goes to S.
  - ONE + consume, no accept → EMPTY.
  - FULL + consume → ONE; M ← S.
  - FULL never accepts.
- `in_ready` = 1 when state is not FULL. It is registered and depends only on state.
- Decode happens before storage, so S holds the already decoded bundle.
- Flush:
  - `flush`=1 forces EMPTY on the next edge, regardless of accept or consume in the same cycle.
  - An instruction presented in the flush cycle is dropped.
- Reset:
  - While `rst_n`=0 at a clock edge, state goes to EMPTY.
  - All outputs go to 0: `out_valid`, `out_alu_op`, `out_mode_sel`, all data outputs and `out_illegal`.
  - `in_ready` goes to 1.
  - Reset asserted mid-transfer discards both entries.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N appears on the outputs after edge N, provided M was empty or consumed at edge N.
- Throughput is 1 instruction per cycle with `out_ready` held high.
- Outputs are stable while `out_valid`=1 and `out_ready`=0.
- `in_ready` falls in the cycle after the second un-consumed accept. It rises in the cycle after a consume from FULL, or after a flush.
- No combinational path from `out_ready` to `in_ready`.

## Configuration
- `ALU_ISSUE_ILLEGAL_TRAP_EN`:
  - Defined: the `out_illegal` port exists. It is stored with each entry and driven from M, and is 1 for unsupported opcodes and for OP with funct7 other than 0000000 or 0100000.
  - Undefined: the port and its storage are absent. Unsupported opcodes issue silently as ADD, mode 00.

## Test plan
- Reset then idle: hold `rst_n`=0 for 2 cycles, release. Required: `in_ready`=1, `out_valid`=0, all outputs 0.
- Back-to-back issue: offer `0x40B50533` (sub) then `0x00A50513` (addi) with `out_ready`=1. Required: out ops 00001/mode 00, then 00000/mode 01, on consecutive cycles.
- Back-pressure: `out_ready`=0, offer 3 instructions. Required: `in_ready`=0 after the 2nd accept, the 3rd is held off. Raise `out_ready`: required order 1, 2, 3 with no loss or duplication.
- Operand forms:
  - LUI `0x123452B7` with `in_rs1`=0xFFFF. Required: `out_rs1`=0, mode 01, ADD.
  - AUIPC. Required: mode 10.
  - SRAI `0x40355513`. Required: op 00111.
- Flush in FULL with simultaneous `in_valid` and `out_ready`. Required: next cycle `out_valid`=0, `in_ready`=1, the offered instruction is not issued.
- With the macro defined, offer opcode `0x7F`. Required: `out_illegal`=1, op 00000, mode 00.
